fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Next-PC generator and fetch initiator. It drives the 32-bit fetch address into the instruction memory / fetch stage, which latches that address on every non-stalled clock edge. It resolves sequential, branch/jump, exception-entry and ERET redirects by fixed priority. A redirect that arrives during a stall is buffered so it is never lost. The block sits between the D-stage branch logic / CP0 and the fetch stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, address the fetch stage loads on reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt handler entry.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  fetch stall; the fetch stage ignores pc32 while high
- br_taken  in  1  D-stage branch resolved taken
- br_target  in  32  branch target
- jump  in  1  D-stage J/JAL/JR/JALR
- jump_target  in  32  jump target
- exc_req  in  1  CP0 exception/interrupt entry request, 1-cycle pulse
- eret  in  1  ERET in commit stage, 1-cycle pulse
- epc  in  32  CP0 EPC, valid while eret is high
- pc32  out  32  next fetch address; combinational
- cur_pc  out  32  address latched by the fetch stage on the last accepted edge
- flush  out  1  high in the cycle an exc/eret redirect is issued; squashes the F/D wrong-path instruction
- pend_valid  out  1  a buffered redirect is waiting

## Operation
- State: cur_pc (32), pend_valid, pend_kind (EXC/ERET), pend_addr (32).
- Source priority, highest first:
  - reset
  - exc_req
  - eret
  - pending buffer
  - jump
  - br_taken
  - cur_pc+4
- The stall gate applies to everything below the pending buffer (jump, br_taken, cur_pc+4); exc/eret are still captured into the buffer while stalled.
- pc32 value by source:
  - exc_req: EXC_VECTOR
  - eret: epc
  - pending: pend_addr
  - jump: jump_target
  - br_taken: br_target
  - else: cur_pc+4, 32-bit wrap, no carry out
- stall=0: cur_pc <= pc32. If the source was exc, eret or pending, flush=1 and pend_valid clears.
- stall=1: cur_pc holds.
  - exc_req or eret high: write the buffer (pend_addr = EXC_VECTOR or epc; pend_kind set). Overwrite only if the new kind has priority ≥ the stored kind, so EXC replaces ERET and ERET never replaces EXC.
  - jump/br_taken are not buffered; D stage holds them stable across a stall.
- exc_req and eret in the same cycle: exc wins and eret is dropped.
- exc_req during a pending ERET with stall=0: EXC_VECTOR is issued and the pending entry is discarded.
- No alignment or range checks; the fetch stage flags misaligned or out-of-range addresses.

## Timing
- Reset:
  - cur_pc=RESET_PC, pend_valid=0, pend_kind=EXC, pend_addr=0, flush=0.
  - pc32 evaluates to RESET_PC+4 in the first cycle after reset, matching the fetch stage's own reset load of RESET_PC.
- Latency:
  - pc32 is combinational from the inputs and state in the same cycle.
  - A redirect becomes cur_pc at the next accepted edge, so the target instruction appears at the fetch output one cycle later.
- flush is combinational and asserted only when stall=0 and the exc/eret/pending source is selected.
- Reset mid-stall or with a pending entry: the buffer is cleared and the pending redirect is lost.
- Stall held for N cycles with one exc pulse: exactly one redirect is issued, on the first cycle with stall=0.

## Structure
- Shared package (e.g. cpu_defs_pkg) holds:
  - RESET_PC and EXC_VECTOR constants
  - the redirect-kind enum {RK_EXC, RK_ERET}
  - PC width localparam 32
- Sub-module pc_redirect_buf: a single-entry priority buffer with capture/overwrite/clear logic, outputs pend_valid/pend_kind/pend_addr. The top holds the priority mux and cur_pc.

## Test plan
- After reset, no stall, 3 cycles: pc32 = 0x3004, 0x3008, 0x300C; cur_pc lags pc32 by one cycle.
- cur_pc=0x3010, jump=1, jump_target=0x3100, br_taken=1, br_target=0x3200 in the same cycle: pc32=0x3100, cur_pc becomes 0x3100, flush=0.
- stall=1 for 3 cycles with exc_req pulsed in cycle 1: pend_valid=1 and cur_pc frozen; on the first unstalled cycle pc32=0x4180, flush=1, then pend_valid=0.
- stall=1 with eret (epc=0x3040) in cycle 1, then exc_req in cycle 2: the buffer holds EXC; on release pc32=0x4180. Reversed order (exc first, then eret): still 0x4180.
- exc_req and eret in the same unstalled cycle, epc=0x3050: pc32=0x4180, flush=1, and a subsequent cycle shows no 0x3050 redirect.
- Pending entry present, reset asserted: pend_valid=0, cur_pc=0x3000, next pc32=0x3004. Also cur_pc=0xFFFF_FFFC with no stall gives pc32=0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants and types for the next-PC generator and its redirect buffer.
package fetch_pc_gen_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'h0000_4180;

    typedef enum logic {
        RK_EXC  = 1'b0,
        RK_ERET = 1'b1
    } redirect_kind_t;

    // An exception outranks an ERET; equal kinds replace each other.
    function automatic logic kind_may_replace(input redirect_kind_t new_kind,
                                              input redirect_kind_t stored_kind);
        return (new_kind == RK_EXC) || (stored_kind == RK_ERET);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_pc_redirect_buf.sv
// Single-entry buffer holding an exc/eret redirect that arrived during a fetch stall.
module fetch_pc_gen_pc_redirect_buf
    import fetch_pc_gen_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                capture,
    input  redirect_kind_t      cap_kind,
    input  logic [PC_W-1:0]     cap_addr,
    input  logic                clear,
    output logic                pend_valid,
    output redirect_kind_t      pend_kind,
    output logic [PC_W-1:0]     pend_addr
);

    logic may_write;

    always_comb begin
        may_write = 1'b0;
        if (capture) begin
            may_write = !pend_valid || kind_may_replace(cap_kind, pend_kind);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_kind  <= RK_EXC;
            pend_addr  <= '0;
        end else if (may_write) begin
            pend_valid <= 1'b1;
            pend_kind  <= cap_kind;
            pend_addr  <= cap_addr;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Next-PC generator: fixed-priority redirect mux, cur_pc register and stall-safe
// buffering of exception/ERET redirects.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jump,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [PC_W-1:0]   epc,
    output logic [PC_W-1:0]   pc32,
    output logic [PC_W-1:0]   cur_pc,
    output logic              flush,
    output logic              pend_valid
);

    redirect_kind_t   pend_kind;
    logic [PC_W-1:0]  pend_addr;
    logic             redirect;
    logic             capture;
    redirect_kind_t   cap_kind;
    logic [PC_W-1:0]  cap_addr;

    always_comb begin
        pc32     = cur_pc + 32'd4;
        redirect = 1'b0;
        if (reset) begin
            pc32 = RESET_PC;
        end else if (exc_req) begin
            pc32     = EXC_VECTOR;
            redirect = 1'b1;
        end else if (eret) begin
            pc32     = epc;
            redirect = 1'b1;
        end else if (pend_valid) begin
            pc32     = pend_addr;
            redirect = 1'b1;
        end else if (jump) begin
            pc32 = jump_target;
        end else if (br_taken) begin
            pc32 = br_target;
        end
    end

    assign flush = redirect && !stall;

    // exc_req wins over a simultaneous eret, so the eret is never captured.
    always_comb begin
        capture  = !reset && stall && (exc_req || eret);
        cap_kind = exc_req ? RK_EXC : RK_ERET;
        cap_addr = exc_req ? EXC_VECTOR : epc;
    end

    fetch_pc_gen_pc_redirect_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .cap_kind   (cap_kind),
        .cap_addr   (cap_addr),
        .clear      (flush),
        .pend_valid (pend_valid),
        .pend_kind  (pend_kind),
        .pend_addr  (pend_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_pc <= RESET_PC;
        end else if (!stall) begin
            cur_pc <= pc32;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, reset-with-pending
// sequence, then randomized stimulus against a rule-level reference model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc32;
    logic [31:0] cur_pc;
    logic        flush;
    logic        pend_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .RESET_PC   (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .pc32        (pc32),
        .cur_pc      (cur_pc),
        .flush       (flush),
        .pend_valid  (pend_valid)
    );

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_pend;
        logic [31:0] exp_cur;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic j, input logic [31:0] jt,
                                input logic b, input logic [31:0] bt,
                                input logic x, input logic e, input logic [31:0] ep,
                                input logic [31:0] xpc, input logic xfl,
                                input logic xpv, input logic [31:0] xcur);
        vec_t v;
        v.stall = s; v.jump = j; v.jt = jt; v.br = b; v.bt = bt;
        v.exc = x; v.eret = e; v.epc = ep;
        v.exp_pc = xpc; v.exp_flush = xfl; v.exp_pend = xpv; v.exp_cur = xcur;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt,
                         input logic x, input logic e, input logic [31:0] ep);
        @(negedge clk);
        reset = r; stall = s; jump = j; jump_target = jt; br_taken = b; br_target = bt;
        exc_req = x; eret = e; epc = ep;
        #1;
    endtask

    // Reference model state (what the fetch stage and redirect buffer should hold)
    logic [31:0] m_cur;
    logic        m_pv;
    logic        m_pk_exc;
    logic [31:0] m_pa;

    localparam logic [31:0] EV = 32'h0000_4180;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0; br_taken = 1'b0;
        br_target = '0; exc_req = 1'b0; eret = 1'b0; epc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset cur_pc", cur_pc, 32'h3000);
        chk("reset pend_valid", {31'b0, pend_valid}, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);

        //            s  j  jt            b  bt            x  e  epc           pc32          fl pv cur
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h3004,     0, 0, 32'h3000));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h3008,     0, 0, 32'h3004));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h300C,     0, 0, 32'h3008));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h3010,     0, 0, 32'h300C));
        tbl.push_back(mk(0, 1, 32'h3100,     1, 32'h3200,     0, 0, 0,            32'h3100,     0, 0, 32'h3010));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h3104,     0, 0, 32'h3100));
        tbl.push_back(mk(0, 0, 0,            1, 32'h3200,     0, 0, 0,            32'h3200,     0, 0, 32'h3104));
        tbl.push_back(mk(1, 0, 0,            0, 0,            1, 0, 0,            EV,           0, 0, 32'h3200));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0, 0,            EV,           0, 1, 32'h3200));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0, 0,            EV,           0, 1, 32'h3200));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            EV,           1, 1, 32'h3200));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h4184,     0, 0, 32'h4180));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1, 32'h3040,     32'h3040,     0, 0, 32'h4184));
        tbl.push_back(mk(1, 0, 0,            0, 0,            1, 0, 0,            EV,           0, 1, 32'h4184));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0, 0,            EV,           0, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            EV,           1, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h4184,     0, 0, 32'h4180));
        tbl.push_back(mk(1, 0, 0,            0, 0,            1, 0, 0,            EV,           0, 0, 32'h4184));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1, 32'h3040,     32'h3040,     0, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 32'h3040,   EV,           1, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h4184,     0, 0, 32'h4180));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 1, 32'h3050,     EV,           1, 0, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 32'h3050,     32'h4184,     0, 0, 32'h4180));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1, 32'h3060,     32'h3060,     0, 0, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 0,            EV,           1, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h4184,     0, 0, 32'h4180));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 1, 32'h3070,     32'h3070,     0, 0, 32'h4184));
        tbl.push_back(mk(0, 1, 32'h5000,     0, 0,            0, 0, 0,            32'h3070,     1, 1, 32'h4184));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h3074,     0, 0, 32'h3070));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0,            0, 0, 0,            32'hFFFFFFFC, 0, 0, 32'h3074));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h0000_0000, 0, 0, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 0,            32'h0000_0004, 0, 0, 32'h0000_0000));

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].stall, tbl[i].jump, tbl[i].jt, tbl[i].br, tbl[i].bt,
                  tbl[i].exc, tbl[i].eret, tbl[i].epc);
            chk($sformatf("vec%0d pc32", i), pc32, tbl[i].exp_pc);
            chk($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, tbl[i].exp_flush});
            chk($sformatf("vec%0d pend_valid", i), {31'b0, pend_valid}, {31'b0, tbl[i].exp_pend});
            chk($sformatf("vec%0d cur_pc", i), cur_pc, tbl[i].exp_cur);
        end

        // Reset while a redirect is buffered: the redirect is lost.
        drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        chk("pre-reset pend_valid", {31'b0, pend_valid}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        chk("post-reset pend_valid", {31'b0, pend_valid}, 32'h0);
        chk("post-reset cur_pc", cur_pc, 32'h3000);
        chk("post-reset pc32", pc32, 32'h3004);
        chk("post-reset flush", {31'b0, flush}, 32'h0);

        m_cur = 32'h3004; m_pv = 1'b0; m_pk_exc = 1'b1; m_pa = '0;

        for (int unsigned n = 0; n < 3000; n++) begin
            logic        r, s, j, b, x, e, red;
            logic [31:0] jt, bt, ep, want;
            r  = ($urandom_range(99) < 2);
            s  = ($urandom_range(99) < 35);
            j  = ($urandom_range(99) < 20);
            b  = ($urandom_range(99) < 25);
            x  = ($urandom_range(99) < 8);
            e  = ($urandom_range(99) < 8);
            jt = $urandom; bt = $urandom; ep = $urandom;
            if ($urandom_range(99) < 5) jt = 32'hFFFFFFFC;
            drive(r, s, j, jt, b, bt, x, e, ep);

            red  = x || e || m_pv;
            want = x ? EV : e ? ep : m_pv ? m_pa : j ? jt : b ? bt : m_cur + 32'd4;
            chk("rand cur_pc", cur_pc, m_cur);
            chk("rand pend_valid", {31'b0, pend_valid}, {31'b0, m_pv});
            if (!r) begin
                chk("rand pc32", pc32, want);
                chk("rand flush", {31'b0, flush}, {31'b0, red && !s});
            end

            if (r) begin
                m_cur = 32'h3000; m_pv = 1'b0; m_pk_exc = 1'b1; m_pa = '0;
            end else if (!s) begin
                m_cur = want;
                if (red) m_pv = 1'b0;
            end else if (x) begin
                m_pv = 1'b1; m_pk_exc = 1'b1; m_pa = EV;
            end else if (e && (!m_pv || !m_pk_exc)) begin
                m_pv = 1'b1; m_pk_exc = 1'b0; m_pa = ep;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
